// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared FSM state type and frame constants for the ball receiver
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RX_YHI    = 3'd1,
    RX_YLO    = 3'd2,
    RX_VY     = 3'd3,
    RX_GRAV   = 3'd4,
    RX_COLL   = 3'd5,
    WAIT_STOP = 3'd6
  } rx_state_t;

  localparam int FRAME_BYTES            = 5;
  localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/rx_timeout_timer.sv
// rtl/rx_timeout_timer.sv - idle-cycle watchdog with clear, enable and expire pulse
module rx_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // A clear in the same cycle as the terminal count wins, so bus activity never times out.
  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ball_rx_decoder.sv
// rtl/ball_rx_decoder.sv - assembles five-byte I2C ball frames into committed ball fields
module ball_rx_decoder
  import i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int FRAME_BYTES    = i2c_pkg::FRAME_BYTES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_start,
  input  logic       i2c_stop,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_valid,
  input  logic       ball_ack,
  output logic [9:0] ball_y,
  output logic [7:0] ball_vy,
  output logic [1:0] gravity_counter,
  output logic       is_collusion,
  output logic       ball_valid,
  output logic       go_right,
  output logic       frame_error,
  output logic       responsing_i2c
);

  localparam rx_state_t LAST_RX = rx_state_t'(3'(FRAME_BYTES));

  rx_state_t  state, st_b;
  logic       err_flag, err_b;
  logic [1:0] sh_yhi, yhi_n;
  logic [7:0] sh_ylo, ylo_n;
  logic [7:0] sh_vy, vy_n;
  logic [1:0] sh_grav, grav_n;
  logic       sh_coll, coll_n;
  logic       timer_expire;

  assign responsing_i2c = (state != IDLE);

  rx_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (i2c_start || i2c_stop || rx_byte_valid),
    .enable(state != IDLE),
    .expire(timer_expire)
  );

  // Byte effects are resolved first so a stop in the same cycle sees the completed frame.
  always_comb begin
    st_b   = state;
    err_b  = err_flag;
    yhi_n  = sh_yhi;
    ylo_n  = sh_ylo;
    vy_n   = sh_vy;
    grav_n = sh_grav;
    coll_n = sh_coll;
    if (rx_byte_valid) begin
      case (state)
        RX_YHI: begin
          yhi_n = rx_byte[1:0];
          err_b = err_b | (|rx_byte[7:2]);
        end
        RX_YLO:  ylo_n = rx_byte;
        RX_VY:   vy_n = rx_byte;
        RX_GRAV: begin
          grav_n = rx_byte[1:0];
          err_b  = err_b | (|rx_byte[7:2]);
        end
        RX_COLL: begin
          coll_n = rx_byte[0];
          err_b  = err_b | (|rx_byte[7:1]);
        end
        WAIT_STOP: err_b = 1'b1;
        default: ;
      endcase
      if (state != IDLE && state != WAIT_STOP) begin
        st_b = (state == LAST_RX) ? WAIT_STOP : rx_state_t'(state + 3'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      err_flag        <= 1'b0;
      sh_yhi          <= '0;
      sh_ylo          <= '0;
      sh_vy           <= '0;
      sh_grav         <= '0;
      sh_coll         <= 1'b0;
      ball_y          <= '0;
      ball_vy         <= '0;
      gravity_counter <= '0;
      is_collusion    <= 1'b0;
      ball_valid      <= 1'b0;
      go_right        <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      ball_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (ball_ack) begin
        go_right <= 1'b0;
      end
      if (i2c_start) begin
        state    <= RX_YHI;
        err_flag <= 1'b0;
        sh_yhi   <= '0;
        sh_ylo   <= '0;
        sh_vy    <= '0;
        sh_grav  <= '0;
        sh_coll  <= 1'b0;
      end else if (state != IDLE) begin
        sh_yhi  <= yhi_n;
        sh_ylo  <= ylo_n;
        sh_vy   <= vy_n;
        sh_grav <= grav_n;
        sh_coll <= coll_n;
        if (i2c_stop) begin
          state    <= IDLE;
          err_flag <= err_b;
          if (st_b == WAIT_STOP && !err_b) begin
            ball_y          <= {yhi_n, ylo_n};
            ball_vy         <= vy_n;
            gravity_counter <= grav_n;
            is_collusion    <= coll_n;
            ball_valid      <= 1'b1;
            go_right        <= 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
        end else if (timer_expire) begin
          state       <= IDLE;
          frame_error <= 1'b1;
        end else begin
          state    <= st_b;
          err_flag <= err_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_ball_rx_decoder.sv
// tb/tb_ball_rx_decoder.sv - directed self-checking bench for ball_rx_decoder
`timescale 1ns/1ps
module tb_ball_rx_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       i2c_start, i2c_stop, rx_byte_valid, ball_ack;
  logic [7:0] rx_byte;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_counter;
  logic       is_collusion, ball_valid, go_right, frame_error, responsing_i2c;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int fcount = 0;

  always #5 clk = ~clk;

  ball_rx_decoder #(
    .TIMEOUT_CYCLES(16),
    .FRAME_BYTES   (5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i2c_start      (i2c_start),
    .i2c_stop       (i2c_stop),
    .rx_byte        (rx_byte),
    .rx_byte_valid  (rx_byte_valid),
    .ball_ack       (ball_ack),
    .ball_y         (ball_y),
    .ball_vy        (ball_vy),
    .gravity_counter(gravity_counter),
    .is_collusion   (is_collusion),
    .ball_valid     (ball_valid),
    .go_right       (go_right),
    .frame_error    (frame_error),
    .responsing_i2c (responsing_i2c)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
    if (ball_valid === 1'b1) vcount++;
    if (frame_error === 1'b1) fcount++;
  endtask

  task automatic idle_inputs();
    i2c_start = 0; i2c_stop = 0; rx_byte_valid = 0; ball_ack = 0; rx_byte = 8'h00;
  endtask

  task automatic do_start();
    i2c_start = 1; cyc(); i2c_start = 0;
  endtask

  task automatic do_stop();
    i2c_stop = 1; cyc(); i2c_stop = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b; rx_byte_valid = 1; cyc(); rx_byte_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); cyc(); cyc(); reset = 0;
    checks++; if ({ball_y, ball_vy, gravity_counter, is_collusion} !== 21'd0) begin
      errors++; $display("FAIL reset_fields got %h want 0", {ball_y, ball_vy, gravity_counter, is_collusion}); end
    checks++; if ({ball_valid, go_right, frame_error, responsing_i2c} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {ball_valid, go_right, frame_error, responsing_i2c}); end
  endtask

  task automatic test_good_frame();
    vcount = 0; fcount = 0;
    do_start();
    checks++; if (responsing_i2c !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", responsing_i2c); end
    send_byte(8'h01); send_byte(8'h2C); send_byte(8'h05); send_byte(8'h02); send_byte(8'h01);
    checks++; if (vcount !== 0) begin errors++; $display("FAIL early_valid got %0d want 0", vcount); end
    do_stop();
    checks++; if (ball_valid !== 1'b1) begin errors++; $display("FAIL good_valid got %b want 1", ball_valid); end
    checks++; if (ball_y !== 10'd300 || ball_vy !== 8'd5) begin
      errors++; $display("FAIL good_y_vy got %0d/%0d want 300/5", ball_y, ball_vy); end
    checks++; if (gravity_counter !== 2'd2 || is_collusion !== 1'b1 || go_right !== 1'b1) begin
      errors++; $display("FAIL good_flags got %0d/%b/%b want 2/1/1", gravity_counter, is_collusion, go_right); end
    checks++; if (responsing_i2c !== 1'b0) begin errors++; $display("FAIL good_idle got %b want 0", responsing_i2c); end
    cyc();
    checks++; if (ball_valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle got %b want 0", ball_valid); end
  endtask

  task automatic test_short_frame();
    vcount = 0; fcount = 0;
    do_start(); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    do_stop();
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", frame_error); end
    cyc();
    checks++; if (vcount !== 0 || ball_y !== 10'd300 || ball_vy !== 8'd5) begin
      errors++; $display("FAIL short_hold got v%0d y%0d vy%0d want v0 y300 vy5", vcount, ball_y, ball_vy); end
    checks++; if (frame_error !== 1'b0 || fcount !== 1) begin
      errors++; $display("FAIL short_err_pulse got %b/%0d want 0/1", frame_error, fcount); end
  endtask

  task automatic test_field_error();
    vcount = 0; fcount = 0;
    do_start();
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    do_stop();
    checks++; if (frame_error !== 1'b1 || vcount !== 0 || ball_y !== 10'd300) begin
      errors++; $display("FAIL field_err got e%b v%0d y%0d want e1 v0 y300", frame_error, vcount, ball_y); end
    vcount = 0; fcount = 0;
    do_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    do_stop();
    checks++; if (fcount !== 1 || vcount !== 0) begin
      errors++; $display("FAIL coll_field_err got f%0d v%0d want f1 v0", fcount, vcount); end
  endtask

  task automatic test_restart();
    vcount = 0; fcount = 0;
    do_start(); send_byte(8'h01); send_byte(8'h02);
    do_start();
    send_byte(8'h00); send_byte(8'h64); send_byte(8'h0A); send_byte(8'h01); send_byte(8'h00);
    do_stop(); cyc();
    checks++; if (vcount !== 1 || fcount !== 0) begin
      errors++; $display("FAIL restart_pulses got v%0d f%0d want v1 f0", vcount, fcount); end
    checks++; if (ball_y !== 10'd100 || ball_vy !== 8'd10 || gravity_counter !== 2'd1 || is_collusion !== 1'b0) begin
      errors++; $display("FAIL restart_data got %0d/%0d/%0d/%b want 100/10/1/0", ball_y, ball_vy, gravity_counter, is_collusion); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    do_start(); send_byte(8'h01); send_byte(8'h02);
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (frame_error === 1'b1) begin n = i; break; end
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL timeout_cycle got %0d want 16", n); end
    checks++; if (responsing_i2c !== 1'b0) begin errors++; $display("FAIL timeout_idle got %b want 0", responsing_i2c); end
  endtask

  task automatic test_ack_commit();
    do_start();
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    ball_ack = 1; do_stop(); ball_ack = 0;
    checks++; if (go_right !== 1'b1 || ball_valid !== 1'b1 || ball_y !== 10'd5) begin
      errors++; $display("FAIL ack_commit got g%b v%b y%0d want g1 v1 y5", go_right, ball_valid, ball_y); end
    ball_ack = 1; cyc(); ball_ack = 0;
    checks++; if (go_right !== 1'b0) begin errors++; $display("FAIL lone_ack got %b want 0", go_right); end
  endtask

  task automatic test_back_to_back();
    // fifth byte together with stop completes the frame
    vcount = 0; fcount = 0;
    do_start(); send_byte(8'h02); send_byte(8'h00); send_byte(8'h7F); send_byte(8'h03);
    rx_byte = 8'h01; rx_byte_valid = 1; i2c_stop = 1; cyc(); rx_byte_valid = 0; i2c_stop = 0;
    checks++; if (ball_valid !== 1'b1 || ball_y !== 10'd512 || ball_vy !== 8'd127 ||
                  gravity_counter !== 2'd3 || is_collusion !== 1'b1) begin
      errors++; $display("FAIL byte_with_stop got v%b %0d/%0d/%0d/%b want v1 512/127/3/1",
                         ball_valid, ball_y, ball_vy, gravity_counter, is_collusion); end
    // overlength frame is dropped
    vcount = 0; fcount = 0;
    do_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    checks++; if (responsing_i2c !== 1'b1) begin errors++; $display("FAIL overlength_busy got %b want 1", responsing_i2c); end
    do_stop();
    checks++; if (fcount !== 1 || vcount !== 0 || ball_y !== 10'd512) begin
      errors++; $display("FAIL overlength got f%0d v%0d y%0d want f1 v0 y512", fcount, vcount, ball_y); end
    // byte coinciding with start is discarded
    vcount = 0; fcount = 0;
    rx_byte = 8'hFF; rx_byte_valid = 1; i2c_start = 1; cyc(); rx_byte_valid = 0; i2c_start = 0;
    send_byte(8'h03); send_byte(8'hFF); send_byte(8'h80); send_byte(8'h00); send_byte(8'h00);
    do_stop();
    checks++; if (vcount !== 1 || ball_y !== 10'd1023 || ball_vy !== 8'h80 || gravity_counter !== 2'd0) begin
      errors++; $display("FAIL start_byte_drop got v%0d y%0d vy%0d g%0d want v1 y1023 vy128 g0",
                         vcount, ball_y, ball_vy, gravity_counter); end
    // events in IDLE are ignored
    vcount = 0; fcount = 0;
    send_byte(8'h55); do_stop();
    checks++; if (vcount !== 0 || fcount !== 0 || responsing_i2c !== 1'b0) begin
      errors++; $display("FAIL idle_ignore got v%0d f%0d b%b want 0 0 0", vcount, fcount, responsing_i2c); end
  endtask

  task automatic test_reset_mid_frame();
    vcount = 0; fcount = 0;
    do_start(); send_byte(8'h01); send_byte(8'h02);
    reset = 1; cyc(); reset = 0; cyc(); cyc();
    checks++; if (fcount !== 0 || responsing_i2c !== 1'b0 || ball_y !== 10'd0 || go_right !== 1'b0) begin
      errors++; $display("FAIL reset_mid_frame got f%0d b%b y%0d g%b want 0 0 0 0",
                         fcount, responsing_i2c, ball_y, go_right); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_field_error();
    test_restart();
    test_timeout();
    test_ack_commit();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
